// File: rtl/tick_counter_regs_pkg.sv
// Shared constants for the tick counter register block.
// Ring geometry, block tag, register offsets and bad-address pattern.
package tick_counter_regs_pkg;

  localparam int UDP_REG_ADDR_WIDTH = 23;

  localparam logic [16:0] TICKS_BLOCK_ADDR = 17'h0_0010;

  localparam logic [31:0] OFF_CTRL        = 32'd0;
  localparam logic [31:0] OFF_ENABLE_MASK = 32'd1;
  localparam logic [31:0] OFF_MODE_MASK   = 32'd2;
  localparam logic [31:0] OFF_CLEAR       = 32'd3;
  localparam logic [31:0] OFF_SNAPSHOT    = 32'd4;
  localparam logic [31:0] OFF_OVF         = 32'd5;
  localparam logic [31:0] CNTR_BASE       = 32'd8;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hbbbb_eeee;

endpackage

// File: rtl/tick_counter_regs_if.sv
// UDP register ring stop bundle.
// master drives the ring fields, slave receives them.
interface tick_counter_regs_if #(
  parameter int SRC_WIDTH = 2
);
  import tick_counter_regs_pkg::*;

  logic                          req;
  logic                          ack;
  logic                          rd_wr_L;
  logic [UDP_REG_ADDR_WIDTH-1:0] addr;
  logic [31:0]                   data;
  logic [SRC_WIDTH-1:0]          src;

  modport master (
    output req, ack, rd_wr_L, addr, data, src
  );

  modport slave (
    input req, ack, rd_wr_L, addr, data, src
  );

endinterface

// File: rtl/tick_counter_chan.sv
// One counter channel: clear beats increment, wrap or saturate at all-ones.
// ovf_pulse flags an increment attempted from all-ones.
module tick_counter_chan #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         sat,
  output logic [W-1:0] value,
  output logic         ovf_pulse
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic         full;

  assign full      = &cnt;
  assign value     = cnt;
  assign ovf_pulse = inc & full & ~clr;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && !(full && sat))
      cnt_nxt = cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/tick_counter_regs.sv
// Multi-channel tick/event counter block on the UDP register ring.
// A HI read latches the whole counter into a shadow returned by LO.
module tick_counter_regs
  import tick_counter_regs_pkg::*;
#(
  parameter int NUM_CNTRS      = 4,
  parameter int CNTR_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 6,
  parameter logic [UDP_REG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0]
    BLOCK_TAG = TICKS_BLOCK_ADDR,
  parameter int SRC_WIDTH      = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  tick_counter_regs_if.slave               reg_in,
  tick_counter_regs_if.master              reg_out,
  input  logic [NUM_CNTRS-1:0]             event_in,
  output logic [NUM_CNTRS*CNTR_WIDTH-1:0]  cntr_value,
  output logic [NUM_CNTRS-1:0]             cntr_enable
);

  localparam int N = NUM_CNTRS;
  localparam int W = CNTR_WIDTH;
  localparam logic [31:0] BAD_START = CNTR_BASE + 32'(2 * N);

  logic [1:0]           ctrl;
  logic [N-1:0]         en_mask;
  logic [N-1:0]         mode_mask;
  logic [N-1:0]         ovf;
  logic [W-1:0]         cnt    [N];
  logic [W-1:0]         shadow [N];
  logic [63:0]          live64 [N];
  logic [N-1:0]         inc;
  logic [N-1:0]         clr;
  logic [N-1:0]         ovf_set;
  logic [N-1:0]         w1c;
  logic [N-1:0]         hi_cap;
  logic                 claim;
  logic                 wr_hit;
  logic                 rd_hit;
  logic                 snap;
  logic [31:0]          off;
  logic [31:0]          rdata;
  logic [SRC_WIDTH-1:0] src_d;

  assign claim = reg_in.req & ~reg_in.ack &
    (reg_in.addr[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]
     == BLOCK_TAG);
  assign off    = 32'(reg_in.addr[REG_ADDR_WIDTH-1:0]);
  assign wr_hit = claim & ~reg_in.rd_wr_L;
  assign rd_hit = claim & reg_in.rd_wr_L;
  assign snap   = wr_hit && (off == OFF_SNAPSHOT);
  assign src_d  = reg_in.src;

  assign cntr_enable = {N{ctrl[0]}} & en_mask;
  assign inc         = cntr_enable & (mode_mask | event_in);

  always_comb begin
    clr    = '0;
    w1c    = '0;
    hi_cap = '0;
    if (wr_hit && (off == OFF_CLEAR))
      clr = reg_in.data[N-1:0];
    if (wr_hit && (off == OFF_OVF))
      w1c = reg_in.data[N-1:0];
    for (int i = 0; i < N; i++)
      hi_cap[i] = rd_hit &&
        (off == CNTR_BASE + 32'(2 * i));
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    tick_counter_chan #(
      .W(W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[i]),
      .clr       (clr[i]),
      .sat       (ctrl[1]),
      .value     (cnt[i]),
      .ovf_pulse (ovf_set[i])
    );
    assign cntr_value[i*W +: W] = cnt[i];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      live64[i]        = '0;
      live64[i][W-1:0] = cnt[i];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (off == OFF_CTRL):        rdata = 32'(ctrl);
      (off == OFF_ENABLE_MASK): rdata = 32'(en_mask);
      (off == OFF_MODE_MASK):   rdata = 32'(mode_mask);
      (off == OFF_OVF):         rdata = 32'(ovf);
      (off >= BAD_START):       rdata = BAD_ADDR_DATA;
      default:                  rdata = '0;
    endcase
    for (int i = 0; i < N; i++) begin
      if (off == CNTR_BASE + 32'(2 * i))
        rdata = live64[i][63:32];
      if (off == CNTR_BASE + 32'(2 * i + 1))
        rdata = shadow[i][31:0];
    end
  end

  // Same-cycle OVF set beats a W1C of that bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= '0;
      en_mask   <= '0;
      mode_mask <= '0;
      ovf       <= '0;
      for (int i = 0; i < N; i++)
        shadow[i] <= '0;
    end else begin
      if (wr_hit) begin
        unique case (1'b1)
          (off == OFF_CTRL):
            ctrl <= reg_in.data[1:0];
          (off == OFF_ENABLE_MASK):
            en_mask <= reg_in.data[N-1:0];
          (off == OFF_MODE_MASK):
            mode_mask <= reg_in.data[N-1:0];
          default: ;
        endcase
      end
      ovf <= (ovf & ~w1c) | ovf_set;
      for (int i = 0; i < N; i++)
        if (snap || hi_cap[i])
          shadow[i] <= cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_out.req     <= 1'b0;
      reg_out.ack     <= 1'b0;
      reg_out.rd_wr_L <= 1'b0;
      reg_out.addr    <= '0;
      reg_out.data    <= '0;
      reg_out.src     <= '0;
    end else begin
      reg_out.req     <= reg_in.req;
      reg_out.ack     <= reg_in.ack | claim;
      reg_out.rd_wr_L <= reg_in.rd_wr_L;
      reg_out.addr    <= reg_in.addr;
      reg_out.data    <= rd_hit ? rdata : reg_in.data;
      reg_out.src     <= src_d;
    end
  end

endmodule
